// File: rtl/sqd_pkg.sv
// Shared types and constants for the sequence-detector stream controller.
package sqd_pkg;

  localparam int unsigned DEF_WORD_W = 16;
  localparam int unsigned DEF_CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A request of 0 bits or more than the word holds means "send the whole word".
  function automatic int unsigned norm_len(input int unsigned len, input int unsigned word_w);
    return ((len == 0) || (len > word_w)) ? word_w : len;
  endfunction

endpackage

// File: rtl/sqd_piso.sv
// Loadable MSB-first shift register with bit index and last-bit flag.
module sqd_piso
  import sqd_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic [CNT_W-1:0]  len,
  input  logic              clr_idx,
  input  logic              shift,
  output logic              msb,
  output logic              nxt,
  output logic [CNT_W-1:0]  idx,
  output logic              last_c
);

  logic [WORD_W-1:0] sr;
  logic [CNT_W-1:0]  len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr    <= '0;
      len_q <= '0;
      idx   <= '0;
    end else begin
      if (load) begin
        sr    <= word;
        len_q <= len;
      end else if (shift) begin
        sr    <= {sr[WORD_W-2:0], 1'b0};
      end
      if (clr_idx) begin
        idx <= '0;
      end else if (shift) begin
        idx <= idx + CNT_W'(1);
      end
    end
  end

  assign msb    = sr[WORD_W-1];
  assign nxt    = sr[WORD_W-2];
  assign last_c = (idx == (len_q - CNT_W'(1)));

endmodule

// File: rtl/sqd_stream_ctrl.sv
// Feeds a parallel word bit-serially into an external Mealy detector and
// collects match count and first-match position.
module sqd_stream_ctrl
  import sqd_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic [CNT_W-1:0]  len_in,
  output logic              det_clr,
  output logic              det_x,
  input  logic              det_z,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  first_pos,
  output logic              found
);

  state_t            state;
  logic              load_c;
  logic              clr_idx_c;
  logic              shift_c;
  logic              msb;
  logic              nxt;
  logic [CNT_W-1:0]  idx;
  logic              last_c;
  logic [CNT_W-1:0]  eff_len_c;

  assign eff_len_c = CNT_W'(norm_len(32'(len_in), WORD_W));
  assign load_c    = (state == IDLE) && start;
  assign clr_idx_c = (state == CLEAR);
  assign shift_c   = (state == SHIFT);

  sqd_piso #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load    (load_c),
    .word    (word_in),
    .len     (eff_len_c),
    .clr_idx (clr_idx_c),
    .shift   (shift_c),
    .msb     (msb),
    .nxt     (nxt),
    .idx     (idx),
    .last_c  (last_c)
  );

  // det_x is registered one step ahead so it equals the shift-register MSB
  // during every SHIFT cycle and is 0 everywhere else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      det_x     <= 1'b0;
      det_clr   <= 1'b1;
      found     <= 1'b0;
      match_cnt <= '0;
      first_pos <= '0;
    end else begin
      done    <= 1'b0;
      det_clr <= 1'b0;
      det_x   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            det_clr   <= 1'b1;
            match_cnt <= '0;
            first_pos <= '0;
            found     <= 1'b0;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          det_x <= msb;
          state <= SHIFT;
        end
        SHIFT: begin
          if (det_z) begin
            match_cnt <= match_cnt + CNT_W'(1);
            if (!found) begin
              first_pos <= idx;
              found     <= 1'b1;
            end
          end
          if (last_c) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            det_x <= nxt;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
